decode_stage: RTL and testbench

- Pipeline Decode stage and ID/EX register, directly downstream of the Fetch stage.
- Consumes InstrD, PCD and PCPlus4D from Fetch.
- Decodes the 17-bit instruction, reads the 16-entry register file and sign-extends immediates. Registers all of it for Execute, which returns PCTargetE/PCSrcE to Fetch.
- Also accepts the Writeback port into the register file and exposes source register numbers to the hazard unit.

---
 rtl/decode_pkg.sv | 42 ++++
 rtl/decode_regfile.sv | 36 +++
 rtl/decode_stage.sv | 180 ++++++++++++++++++
 tb/tb_decode_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU/result selects,
// instruction field positions and the control bundle.
package decode_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_ADDI = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_JAL  = 4'd8
  } opcode_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam int OP_LSB  = 13;
  localparam int HI_LSB  = 9;
  localparam int MID_LSB = 5;
  localparam int LO_LSB  = 1;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       branch;
    logic       jump;
    logic       aluSrc;
    logic       illegal;
    logic [1:0] resultSrc;
    logic [2:0] aluControl;
  } ctrl_t;

endpackage

// File: rtl/decode_regfile.sv
// 16-entry register file: two async reads, one sync write,
// R0 hardwired to zero, same-cycle write-through to readers.
module decode_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [3:0]        wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [3:0]        ra1,
  input  logic [3:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs [16];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we && wa != 4'd0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == 4'd0) rd1 = '0;
    if (ra2 == 4'd0) rd2 = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, control decode, register read,
// immediate extension and the ID/EX pipeline register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 12,
  parameter int INSTR_W = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [PC_W-1:0]    PCD,
  input  logic [PC_W-1:0]    PCPlus4D,
  input  logic               RegWriteW,
  input  logic [3:0]         RdW,
  input  logic [DATA_W-1:0]  ResultW,
  input  logic               StallE,
  input  logic               FlushE,
  output logic [3:0]         Rs1D,
  output logic [3:0]         Rs2D,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [3:0]         Rs1E,
  output logic [3:0]         Rs2E,
  output logic [3:0]         RdE,
  output logic [PC_W-1:0]    PCE,
  output logic [PC_W-1:0]    PCPlus4E,
  output logic               RegWriteE,
  output logic               MemWriteE,
  output logic               BranchE,
  output logic               JumpE,
  output logic               ALUSrcE,
  output logic               IllegalE,
  output logic [1:0]         ResultSrcE,
  output logic [2:0]         ALUControlE
);

  typedef struct packed {
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [3:0]        rs1;
    logic [3:0]        rs2;
    logic [3:0]        rd;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc4;
  } id_ex_t;

  logic [3:0]        op;
  logic [3:0]        fHi;
  logic [3:0]        fMid;
  logic [3:0]        fLo;
  logic [DATA_W-1:0] sext5;
  logic [DATA_W-1:0] sext9;
  ctrl_t             ctrlD;
  logic [3:0]        rdD;
  logic [DATA_W-1:0] immD;
  logic [DATA_W-1:0] rd1D;
  logic [DATA_W-1:0] rd2D;
  id_ex_t            dNext;
  id_ex_t            eReg;

  assign op    = InstrD[OP_LSB +: 4];
  assign fHi   = InstrD[HI_LSB +: 4];
  assign fMid  = InstrD[MID_LSB +: 4];
  assign fLo   = InstrD[LO_LSB +: 4];
  assign sext5 = {{(DATA_W-5){InstrD[4]}}, InstrD[4:0]};
  assign sext9 = {{(DATA_W-9){InstrD[8]}}, InstrD[8:0]};

  always_comb begin
    ctrlD = '0;
    Rs1D  = '0;
    Rs2D  = '0;
    rdD   = '0;
    immD  = '0;
    unique case (1'b1)
      (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR}): begin
        ctrlD.regWrite   = 1'b1;
        ctrlD.aluControl = {1'b0, op[1:0]};
        rdD  = fHi;
        Rs1D = fMid;
        Rs2D = fLo;
      end
      (op == OP_ADDI): begin
        ctrlD.regWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        rdD  = fHi;
        Rs1D = fMid;
        immD = sext5;
      end
      (op == OP_LW): begin
        ctrlD.regWrite  = 1'b1;
        ctrlD.aluSrc    = 1'b1;
        ctrlD.resultSrc = RES_MEM;
        rdD  = fHi;
        Rs1D = fMid;
        immD = sext5;
      end
      (op == OP_SW): begin
        ctrlD.memWrite = 1'b1;
        ctrlD.aluSrc   = 1'b1;
        Rs1D = fHi;
        Rs2D = fMid;
        immD = sext5;
      end
      (op == OP_BEQ): begin
        ctrlD.branch     = 1'b1;
        ctrlD.aluControl = ALU_SUB;
        Rs1D = fHi;
        Rs2D = fMid;
        immD = {sext5[DATA_W-2:0], 1'b0};
      end
      (op == OP_JAL): begin
        ctrlD.jump      = 1'b1;
        ctrlD.regWrite  = 1'b1;
        ctrlD.resultSrc = RES_PC4;
        rdD  = fHi;
        immD = {sext9[DATA_W-2:0], 1'b0};
      end
      default: ctrlD.illegal = 1'b1;
    endcase
  end

  decode_regfile #(.DATA_W(DATA_W)) uRegfile (
    .clk   (clk),
    .reset (reset),
    .we    (RegWriteW),
    .wa    (RdW),
    .wd    (ResultW),
    .ra1   (Rs1D),
    .ra2   (Rs2D),
    .rd1   (rd1D),
    .rd2   (rd2D)
  );

  always_comb begin
    dNext      = '0;
    dNext.ctrl = ctrlD;
    dNext.rd1  = rd1D;
    dNext.rd2  = rd2D;
    dNext.imm  = immD;
    dNext.rs1  = Rs1D;
    dNext.rs2  = Rs2D;
    dNext.rd   = rdD;
    dNext.pc   = PCD;
    dNext.pc4  = PCPlus4D;
  end

  // Flush beats stall so a bubble can always be forced in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eReg <= '0;
    end else if (FlushE) begin
      eReg <= '0;
    end else if (!StallE) begin
      eReg <= dNext;
    end
  end

  assign RD1E        = eReg.rd1;
  assign RD2E        = eReg.rd2;
  assign ImmExtE     = eReg.imm;
  assign Rs1E        = eReg.rs1;
  assign Rs2E        = eReg.rs2;
  assign RdE         = eReg.rd;
  assign PCE         = eReg.pc;
  assign PCPlus4E    = eReg.pc4;
  assign RegWriteE   = eReg.ctrl.regWrite;
  assign MemWriteE   = eReg.ctrl.memWrite;
  assign BranchE     = eReg.ctrl.branch;
  assign JumpE       = eReg.ctrl.jump;
  assign ALUSrcE     = eReg.ctrl.aluSrc;
  assign IllegalE    = eReg.ctrl.illegal;
  assign ResultSrcE  = eReg.ctrl.resultSrc;
  assign ALUControlE = eReg.ctrl.aluControl;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-output queue
// popped one cycle after each decode.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] InstrD;
  logic [11:0] PCD;
  logic [11:0] PCPlus4D;
  logic        RegWriteW;
  logic [3:0]  RdW;
  logic [31:0] ResultW;
  logic        StallE;
  logic        FlushE;
  logic [3:0]  Rs1D, Rs2D;
  logic [31:0] RD1E, RD2E, ImmExtE;
  logic [3:0]  Rs1E, Rs2E, RdE;
  logic [11:0] PCE, PCPlus4E;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [11:0] pc;
    logic [11:0] pc4;
    logic [10:0] ctrl;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  exp_t z;
  exp_t jalExp;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .StallE(StallE), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUSrcE(ALUSrcE), .IllegalE(IllegalE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE)
  );

  function automatic logic [10:0] cb(
    bit rw, bit mw, bit br, bit jp, bit as, bit il,
    logic [1:0] rs, logic [2:0] alu);
    return {rw, mw, br, jp, as, il, rs, alu};
  endfunction

  function automatic exp_t mk(
    logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
    logic [3:0] rs1, logic [3:0] rs2, logic [3:0] rd,
    logic [11:0] pc, logic [10:0] ctrl);
    exp_t e;
    e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.pc = pc; e.pc4 = pc + 12'd4; e.ctrl = ctrl;
    return e;
  endfunction

  function automatic logic [16:0] rIns(
    logic [3:0] op, logic [3:0] rd, logic [3:0] a, logic [3:0] b);
    return {op, rd, a, b, 1'b0};
  endfunction

  function automatic logic [16:0] iIns(
    logic [3:0] op, logic [3:0] a, logic [3:0] b, logic [4:0] imm);
    return {op, a, b, imm};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic checkPop();
    exp_t e;
    if (q.size() == 0) begin
      total++;
      $error("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = q.pop_front();
    chk("RD1E", RD1E, e.rd1);
    chk("RD2E", RD2E, e.rd2);
    chk("ImmExtE", ImmExtE, e.imm);
    chk("Rs1E", {28'd0, Rs1E}, {28'd0, e.rs1});
    chk("Rs2E", {28'd0, Rs2E}, {28'd0, e.rs2});
    chk("RdE", {28'd0, RdE}, {28'd0, e.rd});
    chk("PCE", {20'd0, PCE}, {20'd0, e.pc});
    chk("PCPlus4E", {20'd0, PCPlus4E}, {20'd0, e.pc4});
    chk("ctrl", {21'd0, RegWriteE, MemWriteE, BranchE, JumpE,
                 ALUSrcE, IllegalE, ResultSrcE, ALUControlE},
                {21'd0, e.ctrl});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkPop();
  endtask

  task automatic drive(logic [16:0] i, logic [11:0] pc);
    InstrD   = i;
    PCD      = pc;
    PCPlus4D = pc + 12'd4;
  endtask

  initial begin
    z = '{default: '0};
    reset = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    StallE = 1'b0; FlushE = 1'b0;
    drive(17'($urandom), 12'($urandom));

    q.push_back(z); step();
    drive(rIns(4'h0, 4'd1, 4'd3, 4'd2), 12'h7F0);
    #1;
    chk("Rs1D in reset", {28'd0, Rs1D}, 32'd3);
    chk("Rs2D in reset", {28'd0, Rs2D}, 32'd2);
    q.push_back(z); step();

    reset = 1'b1;
    drive(rIns(4'h0, 4'd1, 4'd0, 4'd0), 12'h010);
    q.push_back(mk(0, 0, 0, 0, 0, 1, 12'h010, cb(1,0,0,0,0,0,2'b00,3'b000)));
    step();

    RegWriteW = 1'b1; RdW = 4'd3; ResultW = 32'h1234_5678;
    drive(iIns(4'h4, 4'd4, 4'd0, 5'b11111), 12'h014);
    q.push_back(mk(0, 0, 32'hFFFF_FFFF, 0, 0, 4, 12'h014,
                   cb(1,0,0,0,1,0,2'b00,3'b000)));
    step();

    RegWriteW = 1'b0;
    drive(rIns(4'h0, 4'd1, 4'd3, 4'd3), 12'h018);
    q.push_back(mk(32'h1234_5678, 32'h1234_5678, 0, 3, 3, 1, 12'h018,
                   cb(1,0,0,0,0,0,2'b00,3'b000)));
    step();

    RegWriteW = 1'b1; RdW = 4'd5; ResultW = 32'hCAFE_0001;
    drive(rIns(4'h1, 4'd2, 4'd5, 4'd0), 12'h01C);
    q.push_back(mk(32'hCAFE_0001, 0, 0, 5, 0, 2, 12'h01C,
                   cb(1,0,0,0,0,0,2'b00,3'b001)));
    step();

    RegWriteW = 1'b0;
    drive(iIns(4'h7, 4'd3, 4'd5, 5'b00011), 12'h020);
    q.push_back(mk(32'h1234_5678, 32'hCAFE_0001, 32'd6, 3, 5, 0, 12'h020,
                   cb(0,0,1,0,0,0,2'b00,3'b001)));
    step();

    drive(iIns(4'h5, 4'd6, 4'd3, 5'b00010), 12'h024);
    q.push_back(mk(32'h1234_5678, 0, 32'd2, 3, 0, 6, 12'h024,
                   cb(1,0,0,0,1,0,2'b01,3'b000)));
    step();

    drive(iIns(4'h6, 4'd5, 4'd3, 5'b10000), 12'h028);
    q.push_back(mk(32'hCAFE_0001, 32'h1234_5678, 32'hFFFF_FFF0, 5, 3, 0,
                   12'h028, cb(0,1,0,0,1,0,2'b00,3'b000)));
    step();

    drive({4'h8, 4'd7, 9'h100}, 12'h02C);
    jalExp = mk(0, 0, 32'hFFFF_FE00, 0, 0, 7, 12'h02C,
                cb(1,0,0,1,0,0,2'b10,3'b000));
    q.push_back(jalExp);
    step();

    StallE = 1'b1;
    RegWriteW = 1'b1; RdW = 4'd8; ResultW = 32'hA5A5_A5A5;
    drive(rIns(4'h2, 4'd9, 4'd3, 4'd5), 12'h030);
    q.push_back(jalExp); step();
    q.push_back(jalExp); step();

    FlushE = 1'b1; RegWriteW = 1'b0;
    q.push_back(z); step();
    FlushE = 1'b0; StallE = 1'b0;

    RegWriteW = 1'b1; RdW = 4'd0; ResultW = 32'hFFFF_FFFF;
    drive(rIns(4'h2, 4'd9, 4'd8, 4'd0), 12'h034);
    q.push_back(mk(32'hA5A5_A5A5, 0, 0, 8, 0, 9, 12'h034,
                   cb(1,0,0,0,0,0,2'b00,3'b010)));
    step();

    RegWriteW = 1'b0;
    drive(rIns(4'h3, 4'd10, 4'd0, 4'd8), 12'h038);
    q.push_back(mk(0, 32'hA5A5_A5A5, 0, 0, 8, 10, 12'h038,
                   cb(1,0,0,0,0,0,2'b00,3'b011)));
    step();

    drive({4'hF, 13'h1FFF}, 12'h03C);
    q.push_back(mk(0, 0, 0, 0, 0, 0, 12'h03C,
                   cb(0,0,0,0,0,1,2'b00,3'b000)));
    step();

    FlushE = 1'b1;
    drive(rIns(4'h0, 4'd1, 4'd3, 4'd5), 12'h040);
    q.push_back(z); step();
    FlushE = 1'b0;

    drive(rIns(4'h0, 4'd1, 4'd3, 4'd3), 12'h044);
    q.push_back(mk(32'h1234_5678, 32'h1234_5678, 0, 3, 3, 1, 12'h044,
                   cb(1,0,0,0,0,0,2'b00,3'b000)));
    step();

    #2;
    reset = 1'b0;
    q.push_back(z);
    #1;
    checkPop();
    q.push_back(z); step();

    reset = 1'b1;
    drive(rIns(4'h0, 4'd1, 4'd3, 4'd3), 12'h048);
    q.push_back(mk(0, 0, 0, 3, 3, 1, 12'h048,
                   cb(1,0,0,0,0,0,2'b00,3'b000)));
    step();

    if (q.size() != 0) begin
      total++;
      $error("FAIL scoreboard: %0d entries left", q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
